// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential request generation to an in-order memory,
// {pc, inst} FIFO towards decode, and redirect flush that drops in-flight responses.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        protocol_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    // discard can exceed DEPTH when redirects arrive faster than the memory drains
    localparam int DW = CW + 2;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [DW-1:0] discard_q, discard_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic          err_q, err_d;
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   fifo_inst_q [DEPTH];

    logic [CW:0]   credits_used;
    logic          do_pop, do_drop, do_push, spurious;
    logic [31:0]   redirect_pc_aligned;

    assign credits_used = {1'b0, count_q} + {1'b0, outstanding_q};
    assign imem_req     = !redirect && (credits_used < DEPTH_W);
    assign imem_addr    = fetch_pc_q[31:2];
    assign inst_valid   = (count_q != '0);
    assign inst         = inst_valid ? fifo_inst_q[head_q] : '0;
    assign inst_pc      = inst_valid ? fifo_pc_q[head_q] : '0;
    assign protocol_err = err_q;

    assign redirect_pc_aligned = redirect_pc & 32'hFFFF_FFFC;
    assign do_pop   = inst_valid && inst_ready;
    assign do_drop  = imem_rvalid && (discard_q != '0);
    assign do_push  = imem_rvalid && !do_drop && (outstanding_q != '0);
    assign spurious = imem_rvalid && (discard_q == '0) && (outstanding_q == '0);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        head_d        = head_q;
        tail_d        = tail_q;
        err_d         = err_q || spurious;
        if (redirect) begin
            fetch_pc_d    = redirect_pc_aligned;
            resp_pc_d     = redirect_pc_aligned;
            count_d       = '0;
            outstanding_d = '0;
            head_d        = '0;
            tail_d        = '0;
            discard_d     = discard_q + DW'(outstanding_q) - DW'(imem_rvalid && !spurious);
        end else begin
            if (imem_req) fetch_pc_d = fetch_pc_q + 32'd4;
            if (do_drop) discard_d = discard_q - DW'(1);
            if (do_push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                tail_d    = tail_q + PW'(1);
            end
            if (do_pop) head_d = head_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            case ({imem_req, do_push})
                2'b10:   outstanding_d = outstanding_q + CW'(1);
                2'b01:   outstanding_d = outstanding_q - CW'(1);
                default: outstanding_d = outstanding_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= '0;
            resp_pc_q     <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            err_q         <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            err_q         <= err_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clock) begin
        if (do_push && !redirect) begin
            fifo_pc_q[tail_q]   <= resp_pc_q;
            fifo_inst_q[tail_q] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: in-order memory model with programmable latency,
// immediate-assertion checks at fixed cycles of each scenario.
module tb_fetch_queue;
    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        protocol_err;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int lat    = 1;
    int nreq;
    int found;
    int          q_due  [$];
    logic [29:0] q_addr [$];
    logic [31:0] wrap_addr [5];
    logic [31:0] wrap_pc   [5];

    always #5 clock = ~clock;

    fetch_queue #(.DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .protocol_err(protocol_err)
    );

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return pc ^ 32'hA5A5_A5A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Start of a cycle (just after the falling edge): present this cycle's response.
    task automatic step();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (q_due.size() > 0 && q_due[0] == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_at({q_addr[0], 2'b00});
            void'(q_due.pop_front());
            void'(q_addr.pop_front());
        end
        #1;
    endtask

    task automatic adv();
        #1;
        if (reset && imem_req) begin
            q_due.push_back(cyc + lat);
            q_addr.push_back(imem_addr);
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        redirect    = 1'b0;
        inst_ready  = 1'b0;
        imem_rvalid = 1'b0;
        q_due.delete();
        q_addr.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checked", passed, total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        #1;
        chk("rst_valid", 32'(inst_valid), 0);
        chk("rst_inst", inst, 0);
        chk("rst_pc", inst_pc, 0);
        chk("rst_err", 32'(protocol_err), 0);

        // First fetch, L=1, core always ready
        do_reset(); lat = 1; inst_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            chk("t1_req", 32'(imem_req), 1);
            chk("t1_addr", 32'(imem_addr), c);
            if (c < 2) chk("t1_valid_lo", 32'(inst_valid), 0);
            else begin
                chk("t1_valid", 32'(inst_valid), 1);
                chk("t1_pc", inst_pc, 4 * (c - 2));
                chk("t1_inst", inst, word_at(4 * (c - 2)));
            end
            adv();
        end

        // Backpressure to full, spurious response while nothing in flight, then drain
        do_reset(); lat = 1; inst_ready = 1'b0; nreq = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (c == 6) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hBAD0_BAD0;
                #1;
            end
            if (imem_req) nreq++;
            if (c >= 4) chk("t2_req_off", 32'(imem_req), 0);
            if (c >= 2) begin
                chk("t2_hold_pc", inst_pc, 0);
                chk("t2_hold_inst", inst, word_at(0));
            end
            chk("t2_err", 32'(protocol_err), (c >= 7) ? 1 : 0);
            adv();
        end
        chk("t2_nreq", nreq, 4);
        inst_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (k == 0) chk("t2_full_pop_req", 32'(imem_req), 0);
            chk("t2_drain_valid", 32'(inst_valid), 1);
            chk("t2_drain_pc", inst_pc, 4 * k);
            chk("t2_drain_inst", inst, word_at(4 * k));
            chk("t2_err_sticky", 32'(protocol_err), 1);
            adv();
        end

        // Redirect with three requests in flight, L=3
        do_reset(); lat = 3; inst_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t3_addr", 32'(imem_addr), c);
            adv();
        end
        redirect = 1'b1; redirect_pc = 32'h40;
        step();
        chk("t3_redir_req", 32'(imem_req), 0);
        adv();
        redirect = 1'b0;
        step();
        chk("t3_restart_req", 32'(imem_req), 1);
        chk("t3_restart_addr", 32'(imem_addr), 32'h10);
        chk("t3_flushed", 32'(inst_valid), 0);
        adv();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t3_gap", 32'(inst_valid), 0);
            adv();
        end
        step();
        chk("t3_first_pc", inst_pc, 32'h40);
        chk("t3_first_inst", inst, word_at(32'h40));
        adv();
        step();
        chk("t3_second_pc", inst_pc, 32'h44);
        chk("t3_err", 32'(protocol_err), 0);
        adv();

        // Redirect in the same cycle as a response and a pop
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            step();
            if (imem_rvalid && inst_valid) found = 1;
            else adv();
        end
        chk("t4_coincide_found", found, 1);
        redirect = 1'b1; redirect_pc = 32'h103;
        #1;
        chk("t4_redir_req", 32'(imem_req), 0);
        adv();
        redirect = 1'b0;
        step();
        chk("t4_flushed", 32'(inst_valid), 0);
        chk("t4_restart_addr", 32'(imem_addr), 32'h40);
        chk("t4_restart_req", 32'(imem_req), 1);
        adv();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_gap", 32'(inst_valid), 0);
            adv();
        end
        step();
        chk("t4_first_valid", 32'(inst_valid), 1);
        chk("t4_first_pc", inst_pc, 32'h100);
        chk("t4_first_inst", inst, word_at(32'h100));
        chk("t4_err", 32'(protocol_err), 0);
        adv();

        // Wrap-around of fetch and response PCs
        do_reset(); lat = 1; inst_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step();
        chk("t6_redir_req", 32'(imem_req), 0);
        adv();
        redirect = 1'b0;
        wrap_addr = '{32'h3FFF_FFFE, 32'h3FFF_FFFF, 32'h0, 32'h1, 32'h2};
        wrap_pc   = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t6_addr", 32'(imem_addr), wrap_addr[k]);
            if (k >= 2) begin
                chk("t6_pc", inst_pc, wrap_pc[k]);
                chk("t6_inst", inst, word_at(wrap_pc[k]));
            end
            adv();
        end

        // Reset asserted mid-stream clears everything immediately
        reset = 1'b0;
        #1;
        chk("t7_valid", 32'(inst_valid), 0);
        chk("t7_pc", inst_pc, 0);
        chk("t7_inst", inst, 0);
        do_reset(); lat = 1; inst_ready = 1'b1;
        step();
        chk("t7_restart_req", 32'(imem_req), 1);
        chk("t7_restart_addr", 32'(imem_addr), 0);
        adv();
        step();
        chk("t7_no_stale", 32'(inst_valid), 0);
        adv();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
